multicycle_issue: RTL and testbench
===================================

// Module: multicycle_issue
// PURPOSE
//  Execute-stage front end for the multi-cycle mul/div unit. Sits between the D/E pipeline
//  register and the mul/div unit. Captures one M-extension op, prepares W-form operands and
//  holds them stable while the unit runs. Converts the unit's done level into a one-shot
//  result handshake, and drives the pipeline stall. Squashes flushed ops without corrupting
//  the unit.
// PARAMETERS
//  XLEN      64  datapath width
//  WDOG_CYC  128 max busy cycles before wdog_err asserts (debug only, no recovery)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  reset        in   1     asynchronous, active-low reset
//  valid_in     in   1     D/E register holds a mul/div op this cycle
//  op_in        in   op_t  decoded op (decode_pkg)
//  is_32instr   in   1     op is a W-form (MULW/DIVW/DIVUW/REMW/REMUW)
//  a_in, b_in   in   XLEN  raw rs1/rs2 values
//  flush        in   1     kill the in-flight op (branch/trap)
//  res_ready    in   1     E/M stage accepts the result this cycle
//  mc_op        out  op_t  op to mul/div unit (held while busy)
//  mc_a, mc_b   out  XLEN  prepared operands (held while busy)
//  mc_result    in   XLEN  unit result
//  mc_doing     in   1     unit busy (low = result valid / idle)
//  stall        out  1     freeze F/D/E (hazard unit)
//  res_valid    out  1     result valid toward E/M
//  result       out  XLEN  final result (W-forms sign-extended)
//  wdog_err     out  1     sticky: BUSY exceeded WDOG_CYC
// BEHAVIOUR
//  Reset: state=IDLE. mc_op=ALU_NOP, mc_a=mc_b=0, result=0. stall=res_valid=wdog_err=0.
//  FSM states: IDLE, LAUNCH, BUSY, HOLD, DRAIN.
//  IDLE:  valid_in & ~flush -> latch op/operands, go to LAUNCH, stall=1 the same cycle.
//  LAUNCH (1 cyc): unit sees the new op, and mc_doing may still be low from the previous
//         op. Ignore mc_doing here. Go to BUSY.
//  BUSY:  ~mc_doing -> capture result, go to HOLD. res_valid=1 the next cycle.
//  HOLD:  res_valid=1, stall=1 until res_ready. On res_ready, go to IDLE, with
//         stall=0 in that same cycle. Exactly one handshake per accepted op.
//  flush: in LAUNCH or BUSY -> DRAIN. In HOLD -> IDLE, result is dropped (res_valid
//         falls next cycle). In IDLE, the op is not accepted. flush wins over valid_in.
//  DRAIN: stall=0, res_valid=0. Operands are held stable until ~mc_doing, then go to
//         IDLE. A new valid_in during DRAIN is not accepted (stall=1 if valid_in).
//  Operand prep for W-forms:
//   - DIVW/REMW: sign-extend [31:0].
//   - DIVUW/REMUW: zero-extend [31:0].
//   - MULW: pass through.
//   - Non-W ops: pass through.
//  Result for W-forms: sext(mc_result[31:0]). Otherwise mc_result unchanged.
//  Total latency with res_ready=1: unit latency + 3 cycles (capture, LAUNCH, HOLD).
//  Watchdog: counter clears on entering LAUNCH and counts in BUSY and DRAIN.
//   Reaching WDOG_CYC sets wdog_err. It stays set until reset.
//  Async reset mid-op returns to IDLE immediately. The unit is reset by the same signal.
//  Back-to-back: an op accepted in the IDLE cycle that follows a HOLD->IDLE exit is legal.
// STRUCTURE
//  decode_pkg: op_t (ALU_NOP, MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW),
//   function is_muldiv(op_t), function is_unsigned_div(op_t).
//  pipes or common: mcstate_t enum (IDLE, LAUNCH, BUSY, HOLD, DRAIN).
//  One sub-module: mc_operand_prep (combinational W-form extension for operands and result).
//  FSM, operand registers and watchdog stay in this module.
// TESTING
//  1. MUL a=3, b=5, stub unit latency 4, res_ready=1 -> result=15. res_valid pulses
//     exactly 1 cycle. stall high from accept until the handshake.
//  2. DIVW a=0xFFFF_FFFF_8000_0000, b=0x2 -> mc_a=0xFFFF_FFFF_8000_0000 and result
//     0xFFFF_FFFF_C000_0000. DIVUW with the same operands -> mc_a=0x8000_0000, result
//     0x0000_0000_4000_0000.
//  3. MULW a=0x7FFF_FFFF, b=2 -> result=0xFFFF_FFFF_FFFF_FFFE.
//  4. res_ready low for 5 cycles in HOLD -> result stable, stall=1 throughout.
//     One handshake only.
//  5. flush in BUSY cycle 2 -> res_valid never asserts, stall=0 next cycle.
//     A valid_in during DRAIN is refused until the unit goes idle.
//  6. Stub unit never clears mc_doing -> wdog_err=1 after 128 cycles. Drop reset
//     mid-BUSY -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/multicycle_issue_pkg.sv
// Shared types and helpers for the multi-cycle mul/div issue front end.
//   op_t        decoded M-extension operation
//   mcstate_t   issue FSM state encoding
//   is_muldiv, is_unsigned_div, is_w_div   op classification helpers
package multicycle_issue_pkg;

    localparam int unsigned XLEN_DEF     = 64;
    localparam int unsigned WDOG_CYC_DEF = 128;

    typedef enum logic [3:0] {
        ALU_NOP,
        MUL,
        MULW,
        DIV,
        DIVU,
        REM,
        REMU,
        DIVW,
        DIVUW,
        REMW,
        REMUW
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        BUSY,
        HOLD,
        DRAIN
    } mcstate_t;

    function automatic logic is_muldiv(op_t op);
        return op != ALU_NOP;
    endfunction

    function automatic logic is_unsigned_div(op_t op);
        return op inside {DIVU, REMU, DIVUW, REMUW};
    endfunction

    // W-form divides/remainders are the only ops whose operands get reshaped
    function automatic logic is_w_div(op_t op);
        return op inside {DIVW, DIVUW, REMW, REMUW};
    endfunction

endpackage

// File: rtl/multicycle_issue_operand_prep.sv
// Combinational W-form shaping for the mul/div unit.
//   op, a_raw, b_raw   -> a_prep, b_prep   operand extension of bits [31:0]
//   res_w, res_raw     -> res_ext          sign-extension of W-form results
module multicycle_issue_operand_prep
    import multicycle_issue_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  op_t             op,
    input  logic [XLEN-1:0] a_raw,
    input  logic [XLEN-1:0] b_raw,
    input  logic            res_w,
    input  logic [XLEN-1:0] res_raw,
    output logic [XLEN-1:0] a_prep,
    output logic [XLEN-1:0] b_prep,
    output logic [XLEN-1:0] res_ext
);

    localparam int unsigned HI_W = XLEN - 32;

    // Signed W divides see sext operands, unsigned ones zext; MULW passes through
    always_comb begin
        a_prep = a_raw;
        b_prep = b_raw;
        if (is_w_div(op)) begin
            if (is_unsigned_div(op)) begin
                a_prep = {{HI_W{1'b0}}, a_raw[31:0]};
                b_prep = {{HI_W{1'b0}}, b_raw[31:0]};
            end else begin
                a_prep = {{HI_W{a_raw[31]}}, a_raw[31:0]};
                b_prep = {{HI_W{b_raw[31]}}, b_raw[31:0]};
            end
        end
    end

    assign res_ext = res_w ? {{HI_W{res_raw[31]}}, res_raw[31:0]} : res_raw;

endmodule

// File: rtl/multicycle_issue.sv
// Execute-stage front end for the multi-cycle mul/div unit.
//   in : clk, reset (async, active-low), valid_in, op_in, is_32instr, a_in, b_in,
//        flush, res_ready, mc_result, mc_doing
//   out: mc_op, mc_a, mc_b (held while the unit runs), stall (combinational),
//        res_valid, result, wdog_err (sticky)
module multicycle_issue
    import multicycle_issue_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned WDOG_CYC = WDOG_CYC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  op_t             op_in,
    input  logic            is_32instr,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic            flush,
    input  logic            res_ready,
    output op_t             mc_op,
    output logic [XLEN-1:0] mc_a,
    output logic [XLEN-1:0] mc_b,
    input  logic [XLEN-1:0] mc_result,
    input  logic            mc_doing,
    output logic            stall,
    output logic            res_valid,
    output logic [XLEN-1:0] result,
    output logic            wdog_err
);

    localparam int unsigned WCW = $clog2(WDOG_CYC + 1);

    mcstate_t        state_q, state_d;
    op_t             op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            w_q, w_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            res_valid_q, res_valid_d;
    logic [WCW-1:0]  wdog_cnt_q, wdog_cnt_d;
    logic            wdog_err_q, wdog_err_d;

    logic [XLEN-1:0] a_prep, b_prep, res_ext;

    multicycle_issue_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .op      (op_in),
        .a_raw   (a_in),
        .b_raw   (b_in),
        .res_w   (w_q),
        .res_raw (mc_result),
        .a_prep  (a_prep),
        .b_prep  (b_prep),
        .res_ext (res_ext)
    );

    // Next-state, operand capture, stall and watchdog
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        w_d         = w_q;
        result_d    = result_q;
        res_valid_d = 1'b0;
        stall       = 1'b0;
        wdog_cnt_d  = wdog_cnt_q;
        wdog_err_d  = wdog_err_q | (wdog_cnt_q == WCW'(WDOG_CYC));

        unique case (state_q)
            IDLE: begin
                if (valid_in && !flush && is_muldiv(op_in)) begin
                    state_d    = LAUNCH;
                    op_d       = op_in;
                    a_d        = a_prep;
                    b_d        = b_prep;
                    w_d        = is_32instr;
                    wdog_cnt_d = '0;
                    stall      = 1'b1;
                end
            end
            // mc_doing can still reflect the previous op here, so it is not looked at
            LAUNCH: begin
                stall   = !flush;
                state_d = flush ? DRAIN : BUSY;
            end
            BUSY: begin
                stall = !flush;
                if (wdog_cnt_q != WCW'(WDOG_CYC)) begin
                    wdog_cnt_d = wdog_cnt_q + WCW'(1);
                end
                if (flush) begin
                    state_d = DRAIN;
                end else if (!mc_doing) begin
                    result_d    = res_ext;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                stall       = !(res_ready || flush);
                res_valid_d = !(res_ready || flush);
                if (res_ready || flush) begin
                    state_d = IDLE;
                end
            end
            // Squashed op still running in the unit; keep its operands stable
            DRAIN: begin
                stall = valid_in;
                if (wdog_cnt_q != WCW'(WDOG_CYC)) begin
                    wdog_cnt_d = wdog_cnt_q + WCW'(1);
                end
                if (!mc_doing) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= ALU_NOP;
            a_q         <= '0;
            b_q         <= '0;
            w_q         <= 1'b0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
            wdog_cnt_q  <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            w_q         <= w_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign mc_op     = op_q;
    assign mc_a      = a_q;
    assign mc_b      = b_q;
    assign result    = result_q;
    assign res_valid = res_valid_q;
    assign wdog_err  = wdog_err_q;

endmodule

// File: tb/tb_multicycle_issue.sv
// Self-checking bench for multicycle_issue with a stub mul/div unit.
module tb_multicycle_issue;
    import multicycle_issue_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_in;
    op_t         op_in;
    logic        is_32instr;
    logic [63:0] a_in, b_in;
    logic        flush;
    logic        res_ready;
    op_t         mc_op;
    logic [63:0] mc_a, mc_b;
    logic [63:0] mc_result;
    logic        mc_doing;
    logic        stall;
    logic        res_valid;
    logic [63:0] result;
    logic        wdog_err;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_issue #(
        .XLEN     (64),
        .WDOG_CYC (128)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .op_in      (op_in),
        .is_32instr (is_32instr),
        .a_in       (a_in),
        .b_in       (b_in),
        .flush      (flush),
        .res_ready  (res_ready),
        .mc_op      (mc_op),
        .mc_a       (mc_a),
        .mc_b       (mc_b),
        .mc_result  (mc_result),
        .mc_doing   (mc_doing),
        .stall      (stall),
        .res_valid  (res_valid),
        .result     (result),
        .wdog_err   (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub unit: starts one cycle after the accept (it sees the op in LAUNCH),
    // stays busy stub_lat cycles, then presents the raw 64-bit result.
    logic stub_go, stub_hang, stub_pend;
    int   stub_lat;
    int   stub_cnt;

    function automatic logic [63:0] unit_calc(input op_t op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            MUL, MULW:   return a * b;
            DIV, DIVW:   return 64'($signed(a) / $signed(b));
            DIVU, DIVUW: return a / b;
            REM, REMW:   return 64'($signed(a) % $signed(b));
            REMU, REMUW: return a % b;
            default:     return 64'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mc_doing  <= 1'b0;
            mc_result <= 64'd0;
            stub_pend <= 1'b0;
            stub_cnt  <= 0;
        end else if (stub_go) begin
            stub_pend <= 1'b1;
        end else if (stub_pend) begin
            stub_pend <= 1'b0;
            mc_doing  <= 1'b1;
            stub_cnt  <= stub_lat;
        end else if (mc_doing && !stub_hang) begin
            if (stub_cnt <= 1) begin
                mc_doing  <= 1'b0;
                mc_result <= unit_calc(mc_op, mc_a, mc_b);
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    typedef struct {
        op_t         op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        int          lat;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] er;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Issue one op now (caller sits just after a negedge with the DUT idle),
    // follow it to its handshake with res_ready=1.
    task automatic run_op(input vec_t v, input string tag);
        bit seen;
        bit stall_ok;
        int lat_seen;
        valid_in   = 1'b1;
        op_in      = v.op;
        is_32instr = v.w;
        a_in       = v.a;
        b_in       = v.b;
        stub_lat   = v.lat;
        stub_go    = 1'b1;
        res_ready  = 1'b1;
        flush      = 1'b0;
        #1 chk({tag, "_accept_stall"}, 64'(stall), 64'd1);
        @(negedge clk);
        valid_in = 1'b0;
        stub_go  = 1'b0;
        op_in    = ALU_NOP;
        a_in     = 64'd0;
        b_in     = 64'd0;
        #1;
        chk({tag, "_mc_op"}, 64'(mc_op), 64'(v.op));
        chk({tag, "_mc_a"}, mc_a, v.ea);
        chk({tag, "_mc_b"}, mc_b, v.eb);
        seen     = 1'b0;
        stall_ok = 1'b1;
        lat_seen = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) begin
                seen     = 1'b1;
                lat_seen = i;
                break;
            end
            if (!stall) stall_ok = 1'b0;
        end
        chk({tag, "_res_valid_seen"}, 64'(seen), 64'd1);
        chk({tag, "_stall_while_busy"}, 64'(stall_ok), 64'd1);
        chk({tag, "_latency"}, 64'(lat_seen), 64'(v.lat + 1));
        chk({tag, "_result"}, result, v.er);
        chk({tag, "_stall_at_handshake"}, 64'(stall), 64'd0);
        @(negedge clk);
        #1 chk({tag, "_res_valid_one_shot"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        bit   ok_a, ok_stall, ok_rv, flag;
        int   hs;

        vecs[0] = '{MUL,   1'b0, 64'd3, 64'd5, 4, 64'd3, 64'd5, 64'd15};
        vecs[1] = '{DIVW,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 6,
                    64'hFFFF_FFFF_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000};
        vecs[2] = '{DIVUW, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 3,
                    64'h0000_0000_8000_0000, 64'd2, 64'h0000_0000_4000_0000};
        vecs[3] = '{MULW,  1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 3,
                    64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4] = '{REMW,  1'b1, 64'h0000_0001_FFFF_FFF9, 64'hFFFF_FFFF_0000_0002, 1,
                    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{REMUW, 1'b1, 64'hFFFF_FFFF_0000_000B, 64'h1234_5678_0000_0003, 2,
                    64'h0000_0000_0000_000B, 64'd3, 64'd2};
        vecs[6] = '{DIV,   1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5,
                    64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2};
        vecs[7] = '{MUL,   1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0003, 2,
                    64'h0000_0001_0000_0000, 64'h0000_0001_0000_0003, 64'h0000_0003_0000_0000};
        vecs[8] = '{DIVU,  1'b0, 64'hFFFF_FFFF_8000_0000, 64'd2, 2,
                    64'hFFFF_FFFF_8000_0000, 64'd2, 64'h7FFF_FFFF_C000_0000};

        reset      = 1'b0;
        valid_in   = 1'b0;
        op_in      = ALU_NOP;
        is_32instr = 1'b0;
        a_in       = 64'd0;
        b_in       = 64'd0;
        flush      = 1'b0;
        res_ready  = 1'b0;
        stub_go    = 1'b0;
        stub_hang  = 1'b0;
        stub_lat   = 1;

        #13;
        chk("rst_mc_op", 64'(mc_op), 64'(ALU_NOP));
        chk("rst_mc_a", mc_a, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_wdog_err", 64'(wdog_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table: back-to-back ops, each issued in the IDLE cycle after the previous handshake
        for (int k = 0; k < 9; k++) begin
            run_op(vecs[k], $sformatf("vec%0d", k));
        end

        // Consumer holds off for 5 cycles in HOLD
        valid_in = 1'b1; op_in = MUL; is_32instr = 1'b0; a_in = 64'd6; b_in = 64'd7;
        stub_lat = 2; stub_go = 1'b1; res_ready = 1'b0;
        @(negedge clk);
        valid_in = 1'b0; stub_go = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) begin flag = 1'b1; break; end
        end
        chk("hold_res_valid_seen", 64'(flag), 64'd1);
        ok_a = 1'b1; ok_stall = 1'b1; ok_rv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (result !== 64'd42) ok_a = 1'b0;
            if (!stall) ok_stall = 1'b0;
            if (!res_valid) ok_rv = 1'b0;
            @(negedge clk);
            #1;
        end
        chk("hold_result_stable", 64'(ok_a), 64'd1);
        chk("hold_stall_high", 64'(ok_stall), 64'd1);
        chk("hold_res_valid_high", 64'(ok_rv), 64'd1);
        chk("hold_result", result, 64'd42);
        res_ready = 1'b1;
        #1 chk("hold_stall_release", 64'(stall), 64'd0);
        hs = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (res_valid && res_ready) hs++;
        end
        chk("hold_single_handshake", 64'(hs), 64'd1);

        // Flush while in HOLD drops the result
        valid_in = 1'b1; op_in = MUL; a_in = 64'd2; b_in = 64'd2; stub_lat = 1; stub_go = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        valid_in = 1'b0; stub_go = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) begin flag = 1'b1; break; end
        end
        chk("hflush_res_valid_seen", 64'(flag), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 chk("hflush_res_valid_drop", 64'(res_valid), 64'd0);
        res_ready = 1'b1;
        @(negedge clk);
        #1 chk("hflush_stays_low", 64'(res_valid), 64'd0);

        // Flush in BUSY cycle 2, then a new op knocks during DRAIN
        valid_in = 1'b1; op_in = DIV; is_32instr = 1'b0; a_in = 64'h64; b_in = 64'd5;
        stub_lat = 10; stub_go = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; stub_go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("drain_stall_low", 64'(stall), 64'd0);
        chk("drain_res_valid_low", 64'(res_valid), 64'd0);
        valid_in = 1'b1; op_in = MUL; a_in = 64'd9; b_in = 64'd9;
        #1 chk("drain_refuse_stall", 64'(stall), 64'd1);
        ok_a = 1'b1; ok_stall = 1'b1; ok_rv = 1'b1; flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) ok_rv = 1'b0;
            if (!stall) ok_stall = 1'b0;
            if (mc_a !== 64'h64) ok_a = 1'b0;
            if (!mc_doing) begin flag = 1'b1; break; end
        end
        chk("drain_unit_idle", 64'(flag), 64'd1);
        chk("drain_no_res_valid", 64'(ok_rv), 64'd1);
        chk("drain_refuse_stall_held", 64'(ok_stall), 64'd1);
        chk("drain_operands_held", 64'(ok_a), 64'd1);
        @(negedge clk);
        v = '{MUL, 1'b0, 64'd9, 64'd9, 2, 64'd9, 64'd9, 64'd81};
        run_op(v, "after_drain");

        // Hung unit trips the watchdog; async reset mid-BUSY
        valid_in = 1'b1; op_in = MUL; is_32instr = 1'b0; a_in = 64'h11; b_in = 64'h22;
        stub_lat = 2; stub_hang = 1'b1; stub_go = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; stub_go = 1'b0;
        repeat (100) @(negedge clk);
        #1 chk("wdog_not_early", 64'(wdog_err), 64'd0);
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (wdog_err) begin flag = 1'b1; break; end
        end
        chk("wdog_err_set", 64'(flag), 64'd1);
        chk("wdog_stall_still_high", 64'(stall), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_mc_op", 64'(mc_op), 64'(ALU_NOP));
        chk("arst_mc_a", mc_a, 64'd0);
        chk("arst_mc_b", mc_b, 64'd0);
        chk("arst_result", result, 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_res_valid", 64'(res_valid), 64'd0);
        chk("arst_wdog_err", 64'(wdog_err), 64'd0);
        stub_hang = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        v = '{MULW, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 3,
              64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 64'd0};
        run_op(v, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
